// File: rtl/axil_test_reg.sv
// axil_test_reg: AXI4-Lite smoke-test register bank (REG1/REG2 RW, REG3 = REG1+REG2, REG4 = write count).
// Ports: clk, rst (async active-high); AXI-Lite slave channels AW/W/B/AR/R prefixed s_axi_.
// Build option: define TEST_REG_SLVERR_EN to answer unmapped or read-only accesses with SLVERR.
module axil_test_reg #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_W-1:0]     s_axi_wdata,
  input  logic [DATA_W/8-1:0]   s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_W-1:0]     s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_W-1:0]     s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);
`ifdef TEST_REG_SLVERR_EN
  localparam logic SLVERR_EN = 1'b1;
`else
  localparam logic SLVERR_EN = 1'b0;
`endif
  typedef enum logic [2:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_COMMIT, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [ADDR_W-3:0] waddr;
  logic [DATA_W-1:0] wdata_q, reg1, reg2, reg3, reg4, reg1_n, reg2_n, rd_val;
  logic [DATA_W/8-1:0] wstrb_q;
  logic aw_hs, w_hs, ar_hs, commit, upd, wr_ok, rd_hi;
  logic unused;
  assign unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  // Only REG1/REG2 are writable; anything else is dropped (and not counted).
  assign wr_ok = (waddr[ADDR_W-3:2] == '0) && !waddr[1];
  assign rd_hi = s_axi_araddr[ADDR_W-1:4] == '0;
  assign commit = w_state == W_COMMIT;
  always_comb begin
    s_axi_awready = !rst && (w_state == W_IDLE || w_state == W_HAVE_D);
    s_axi_wready = !rst && (w_state == W_IDLE || w_state == W_HAVE_A);
    s_axi_bvalid = w_state == W_RESP;
    aw_hs = s_axi_awvalid && s_axi_awready;
    w_hs = s_axi_wvalid && s_axi_wready;
    w_next = w_state;
    case (w_state)
      W_IDLE:   w_next = (aw_hs && w_hs) ? W_COMMIT : aw_hs ? W_HAVE_A : w_hs ? W_HAVE_D : W_IDLE;
      W_HAVE_A: w_next = w_hs ? W_COMMIT : W_HAVE_A;
      W_HAVE_D: w_next = aw_hs ? W_COMMIT : W_HAVE_D;
      W_COMMIT: w_next = W_RESP;
      W_RESP:   w_next = s_axi_bready ? W_IDLE : W_RESP;
      default:  w_next = W_IDLE;
    endcase
  end
  // Reads stall through the commit cycle and the following REG3 update cycle so they observe committed data.
  always_comb begin
    s_axi_arready = !rst && r_state == R_IDLE && !commit && !upd;
    s_axi_rvalid = r_state == R_RESP;
    ar_hs = s_axi_arvalid && s_axi_arready;
    r_next = r_state == R_IDLE ? (ar_hs ? R_RESP : R_IDLE) : (s_axi_rready ? R_IDLE : R_RESP);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  always_comb begin
    reg1_n = reg1;
    reg2_n = reg2;
    for (int i = 0; i < DATA_W/8; i++) begin
      reg1_n[8*i +: 8] = (commit && wr_ok && !waddr[0] && wstrb_q[i]) ? wdata_q[8*i +: 8] : reg1[8*i +: 8];
      reg2_n[8*i +: 8] = (commit && wr_ok && waddr[0] && wstrb_q[i]) ? wdata_q[8*i +: 8] : reg2[8*i +: 8];
    end
    rd_val = !rd_hi ? '0 : s_axi_araddr[3] ? (s_axi_araddr[2] ? reg4 : reg3) : (s_axi_araddr[2] ? reg2 : reg1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      waddr <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      reg1 <= '0;
      reg2 <= '0;
      reg3 <= '0;
      reg4 <= '0;
      upd <= 1'b0;
      s_axi_bresp <= 2'b00;
      s_axi_rdata <= '0;
      s_axi_rresp <= 2'b00;
    end else begin
      if (aw_hs) waddr <= s_axi_awaddr[ADDR_W-1:2];
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      reg1 <= reg1_n;
      reg2 <= reg2_n;
      // REG3 takes the post-write operands so it lands on the edge that raises bvalid.
      if (commit) begin
        reg3 <= reg1_n + reg2_n;
        reg4 <= wr_ok ? reg4 + 1'b1 : reg4;
        s_axi_bresp <= (SLVERR_EN && !wr_ok) ? 2'b10 : 2'b00;
      end
      upd <= commit;
      if (ar_hs) begin
        s_axi_rdata <= rd_val;
        s_axi_rresp <= (SLVERR_EN && !rd_hi) ? 2'b10 : 2'b00;
      end
    end
endmodule

// File: tb/tb_axil_test_reg.sv
// tb_axil_test_reg: directed self-checking bench for axil_test_reg.
module tb_axil_test_reg;
  localparam int ADDR_W = 16;
`ifdef TEST_REG_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [ADDR_W-1:0] awaddr = '0, araddr = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [31:0] wdata = '0, rdata;
  logic [3:0] wstrb = '0;
  logic [1:0] bresp, rresp;
  int n_vec = 0, n_err = 0;
  logic [31:0] d;
  logic [1:0] r;
  always #5 clk = ~clk;
  axil_test_reg #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Write with W presented w_lead cycles before AW (0 = same cycle).
  task automatic wr(input logic [15:0] a, input logic [31:0] dat, input logic [3:0] s, input int w_lead, output logic [1:0] resp);
    int t;
    bit aw_done, w_done, hs_aw, hs_w;
    awaddr = a; wdata = dat; wstrb = s; wvalid = 1'b1; awvalid = (w_lead == 0);
    aw_done = 0; w_done = 0; t = 0;
    while (!(aw_done && w_done) && t < 50) begin
      #1;
      hs_aw = awvalid && awready;
      hs_w = wvalid && wready;
      @(posedge clk);
      @(negedge clk);
      if (hs_aw) begin awvalid = 1'b0; aw_done = 1; end
      if (hs_w) begin wvalid = 1'b0; w_done = 1; end
      t++;
      if (t >= w_lead && !aw_done) awvalid = 1'b1;
    end
    check("wr_handshake", {31'd0, aw_done && w_done}, 32'd1);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1; t = 0;
    #1;
    while (!bvalid && t < 20) begin @(negedge clk); #1; t++; end
    check("wr_bvalid", {31'd0, bvalid}, 32'd1);
    resp = bresp;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
  endtask
  task automatic rd(input logic [15:0] a, output logic [31:0] dat, output logic [1:0] resp);
    int t;
    araddr = a; arvalid = 1'b1; t = 0;
    #1;
    while (!arready && t < 20) begin @(negedge clk); #1; t++; end
    check("rd_arready", {31'd0, arready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    #1;
    check("rd_latency1", {31'd0, rvalid}, 32'd1);
    dat = rdata; resp = rresp; rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #1;
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    // Same-cycle AW+W to REG1, watching commit/update stall and bvalid at T+2.
    awaddr = 16'h0; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    check("idle_ready", {30'd0, awready, wready}, 32'd3);
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    #1;
    check("commit_bvalid", {31'd0, bvalid}, 32'd0);
    check("commit_arready", {31'd0, arready}, 32'd0);
    @(negedge clk);
    #1;
    check("t2_bvalid", {31'd0, bvalid}, 32'd1);
    check("upd_arready", {31'd0, arready}, 32'd0);
    check("bresp_ok", {30'd0, bresp}, 32'd0);
    @(negedge clk);
    #1;
    check("resp_arready", {31'd0, arready}, 32'd1);
    check("bvalid_held", {31'd0, bvalid}, 32'd1);
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    wr(16'h4, 32'h01010101, 4'hF, 0, r);
    rd(16'h8, d, r);
    check("sum", d, 32'h13355779);
    check("sum_rresp", {30'd0, r}, 32'd0);
    rd(16'hC, d, r);
    check("cnt2", d, 32'd2);
    // Carry out of the sum is dropped.
    wr(16'h0, 32'h80000000, 4'hF, 0, r);
    wr(16'h4, 32'h80000001, 4'hF, 0, r);
    rd(16'h8, d, r);
    check("sum_carry", d, 32'h00000001);
    // Byte strobes.
    wr(16'h0, 32'hAABBCCDD, 4'hF, 0, r);
    wr(16'h0, 32'h11223344, 4'h5, 0, r);
    rd(16'h0, d, r);
    check("strb5", d, 32'hAA22CC44);
    wr(16'h4, 32'hFFFFFFFF, 4'h0, 0, r);
    rd(16'h4, d, r);
    check("strb0_reg2", d, 32'h80000001);
    rd(16'hC, d, r);
    check("strb0_cnt", d, 32'd7);
    // W three cycles ahead of AW.
    wr(16'h4, 32'h5, 4'hF, 3, r);
    #1;
    check("no_dup_bvalid", {31'd0, bvalid}, 32'd0);
    rd(16'h7, d, r);
    check("wfirst_reg2_lowbits", d, 32'h5);
    rd(16'hC, d, r);
    check("wfirst_cnt", d, 32'd8);
    rd(16'h8, d, r);
    check("wfirst_sum", d, 32'hAA22CC49);
    // Read-only and unmapped accesses.
    wr(16'h8, 32'h0000FFFF, 4'hF, 0, r);
    check("ro_bresp", {30'd0, r}, {30'd0, ERR});
    wr(16'h10, 32'h1, 4'hF, 0, r);
    check("unmap_bresp", {30'd0, r}, {30'd0, ERR});
    rd(16'h8, d, r);
    check("ro_sum_kept", d, 32'hAA22CC49);
    rd(16'hC, d, r);
    check("ro_cnt_kept", d, 32'd8);
    rd(16'h0, d, r);
    check("unmap_reg1_kept", d, 32'hAA22CC44);
    rd(16'h20, d, r);
    check("unmap_rdata", d, 32'd0);
    check("unmap_rresp", {30'd0, r}, {30'd0, ERR});
    // Reset while B response is stalled.
    awaddr = 16'h0; wdata = 32'hDEAD0001; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_bvalid", {31'd0, bvalid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_bvalid", {31'd0, bvalid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(16'(4 * i), d, r);
      check($sformatf("post_rst_reg%0d", i + 1), d, 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axil_test_reg.md
Name: axil_test_reg

Overview:
- AXI4-Lite slave register bank on the card's user register path, downstream of the shell's AXI-Lite master.
- Holds two writable operands (REG1, REG2), a read-only registered sum (REG3 = REG1 + REG2) and a read-only write counter (REG4).
- Serves as the smoke-test target for host register access and for the card-level simulation bench.

Parameters:
- ADDR_W, 16, AXI-Lite address width; only bits [3:2] decode, bits [1:0] ignored.
- DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- s_axi_awaddr  in  ADDR_W  write address.
- s_axi_awvalid  in  1; s_axi_awready  out  1.
- s_axi_wdata  in  32; s_axi_wstrb  in  4; s_axi_wvalid  in  1; s_axi_wready  out  1.
- s_axi_bresp  out  2; s_axi_bvalid  out  1; s_axi_bready  in  1.
- s_axi_araddr  in  ADDR_W; s_axi_arvalid  in  1; s_axi_arready  out  1.
- s_axi_rdata  out  32; s_axi_rresp  out  2; s_axi_rvalid  out  1; s_axi_rready  in  1.

Behaviour:
- Reset: one clock; rst is asynchronous, active-high. All registers, all *ready/*valid, bresp, rresp and rdata are 0; both FSMs return to IDLE. Reset mid-transaction drops it and issues no response.
- Address map (addr[ADDR_W-1:4] must be 0 to be mapped):
  - 0x0 REG1, RW.
  - 0x4 REG2, RW.
  - 0x8 REG3, RO.
  - 0xC REG4, RO.
  - All other addresses unmapped.
- Write FSM states: W_IDLE, W_HAVE_A, W_HAVE_D, W_COMMIT, W_RESP.
  - In W_IDLE, awready = wready = 1. AW and W may arrive in either order or in the same cycle.
  - Same cycle -> W_COMMIT.
  - AW only -> W_HAVE_A, where awready = 0 and wready = 1.
  - W only -> W_HAVE_D, where wready = 0 and awready = 1.
  - Second half accepted -> W_COMMIT.
  - W_COMMIT lasts one cycle and applies the write:
    - Byte lane i is updated only if wstrb[i] = 1. wstrb = 0 updates nothing but still counts.
    - Writes to REG3/REG4 are dropped.
    - REG4 increments, wrapping 0xFFFFFFFF -> 0, on every committed write to 0x0 or 0x4. It does not increment for writes to RO or unmapped addresses.
    - Then -> W_RESP.
  - W_RESP: bvalid = 1 and bresp = OKAY, held until bready. On the bready handshake -> W_IDLE.
  - Minimum write turnaround: AW+W handshake at cycle T, bvalid at T+2.
- REG3: registered sum, updated the cycle after W_COMMIT, i.e. on the same edge that raises bvalid.
  - Sum is modulo 2^32; the carry is discarded.
  - Any read issued after the B handshake returns the new sum.
- Read FSM states: R_IDLE, R_RESP.
  - arready = 1 in R_IDLE except while the write FSM is in W_COMMIT or the REG3 update cycle; during those the read is stalled so it sees committed data.
  - On the AR handshake, rdata is captured from the mapped register, or 0 if unmapped; rvalid = 1 next cycle (read latency 1). Then -> R_RESP.
  - R_RESP: rvalid, rdata and rresp are held until rready, then -> R_IDLE.
  - At most one outstanding read and one outstanding write.
- Simultaneous read and write are independent except for the stall rule above.

Optional Feature:
- TEST_REG_SLVERR_EN defined:
  - Writes to unmapped or RO addresses return bresp = SLVERR (2'b10); the data is dropped.
  - Reads of unmapped addresses return rresp = SLVERR with rdata = 0.
- Undefined: all responses are OKAY; unmapped reads return 0.

Test Plan:
- Write REG1 = 0x12345678 and REG2 = 0x01010101 (wstrb 0xF), read 0x8 -> 0x13355779 OKAY; read 0xC -> 0x00000002.
- Write REG1 = 0x80000000 and REG2 = 0x80000001, read REG3 -> 0x00000001 (carry dropped).
- REG1 = 0xAABBCCDD, then write 0x11223344 with wstrb 0x5 -> REG1 reads 0xAA22CC44.
- W presented 3 cycles before AW to 0x4 with data 0x5 -> single bvalid; REG2 reads 0x5; no duplicate commit (REG4 +1 only).
- Write 0x8 and read 0x20 -> REG3 unchanged, REG4 unchanged, rdata 0. Response OKAY without the macro, SLVERR with TEST_REG_SLVERR_EN.
- Assert rst while bvalid = 1 and bready = 0 -> bvalid drops asynchronously; REG1..REG4 read 0 after release.
